conv_sa_ctrl: RTL

- Sequencing controller for the 2x2 output-stationary systolic convolution array: 3x3 kernel over a 4x4 map, giving a 2x2 result.
- Runs weight loading into the PE weight registers, the accumulator clear, and the diagonal-skewed 9-step MAC wavefront.
- Presents the result with a valid/ready handshake and reports completion.
- Sits between the top-level command interface (start, weight_load) and the PE array datapath. It produces only control signals and indices; it carries no data.

---
 rtl/conv_sa_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_sa_ctrl
// Description : Sequencing controller for a 2x2 output-stationary systolic
//               convolution array (3x3 kernel over a 4x4 map). It drives the
//               weight load, the accumulator clear, and the diagonal-skewed
//               MAC wavefront. It also presents the result with a valid/ready
//               handshake. Control and indices only; no data passes through.
// Ports       : clk, rst (async, active-high)
//               start, weight_load, out_ready        - command / handshake in
//               w_we, w_addr                         - weight register write
//               pe_clr, pe_en[p], pe_k[p]            - PE array control
//               out_valid, busy, weights_valid       - status
//               start_err, done                      - one-cycle pulses
//               cycle_cnt (only with CONV_SA_CTRL_PERF_EN defined)
// Options     : CONV_SA_CTRL_PERF_EN adds a saturating 16-bit cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sa_ctrl #(
  parameter int KSIZE = 3,
  parameter int ARR   = 2,
  parameter int IDX_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       weight_load,
  input  logic                       out_ready,
  output logic                       w_we,
  output logic [IDX_W-1:0]           w_addr,
  output logic                       pe_clr,
  output logic [ARR*ARR-1:0]         pe_en,
  output logic [ARR*ARR*IDX_W-1:0]   pe_k,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       weights_valid,
  output logic                       start_err,
  output logic                       done
`ifdef CONV_SA_CTRL_PERF_EN
  ,
  output logic [15:0]                cycle_cnt
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_CLEAR    = 3'd2;
  localparam logic [2:0] S_COMPUTE  = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_OUT_WAIT = 3'd5;

  // Last kernel index, and last wavefront step (the far diagonal lags 2*(ARR-1))
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(KSIZE * KSIZE - 1);
  localparam logic [IDX_W-1:0] T_LAST = IDX_W'(KSIZE * KSIZE + 2 * (ARR - 1) - 1);
  localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [IDX_W-1:0]         cnt;        // weight address in LOAD_W, step t in COMPUTE
  logic [IDX_W-1:0]         cnt_nxt;

  logic                     w_we_nxt;
  logic [IDX_W-1:0]         w_addr_nxt;
  logic                     pe_clr_nxt;
  logic [ARR*ARR-1:0]       pe_en_nxt;
  logic [ARR*ARR*IDX_W-1:0] pe_k_nxt;
  logic                     out_valid_nxt;
  logic                     busy_nxt;
  logic                     weights_valid_nxt;
  logic                     start_err_nxt;
  logic                     done_nxt;
  logic                     compute_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        // weight_load wins; a coincident start is dropped silently
        if (weight_load) begin
          state_nxt = S_LOAD_W;
        end else if (start && weights_valid) begin
          state_nxt = S_CLEAR;
        end
      end
      S_LOAD_W: begin
        if (cnt == K_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + C_ONE;
        end
      end
      S_CLEAR: begin
        state_nxt = S_COMPUTE;
        cnt_nxt   = '0;
      end
      S_COMPUTE: begin
        if (cnt == T_LAST) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + C_ONE;
        end
      end
      S_DRAIN: begin
        state_nxt = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are decoded from the next state/counter so that the
  // output registers line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_we_nxt          = (state_nxt == S_LOAD_W);
    w_addr_nxt        = (state_nxt == S_LOAD_W) ? cnt_nxt : '0;
    pe_clr_nxt        = (state_nxt == S_CLEAR);
    out_valid_nxt     = (state_nxt == S_OUT_WAIT);
    busy_nxt          = (state_nxt != S_IDLE);
    weights_valid_nxt = weights_valid | ((state == S_LOAD_W) && (cnt == K_LAST));
    start_err_nxt     = (state == S_IDLE) && start && !weight_load && !weights_valid;
    done_nxt          = (state == S_OUT_WAIT) && out_ready;
  end

  assign compute_nxt = (state_nxt == S_COMPUTE);

  // Each PE runs the kernel sequence delayed by its diagonal index r+c.
  genvar p;
  generate
    for (p = 0; p < ARR * ARR; p++) begin : g_pe
      localparam logic [IDX_W-1:0] DIAG = IDX_W'(p / ARR + p % ARR);
      logic [IDX_W-1:0] offs;
      logic             act;
      assign offs                      = cnt_nxt - DIAG;
      assign act                       = compute_nxt && (cnt_nxt >= DIAG) && (offs <= K_LAST);
      assign pe_en_nxt[p]              = act;
      assign pe_k_nxt[p*IDX_W +: IDX_W] = act ? offs : '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_we          <= 1'b0;
      w_addr        <= '0;
      pe_clr        <= 1'b0;
      pe_en         <= '0;
      pe_k          <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      weights_valid <= 1'b0;
      start_err     <= 1'b0;
      done          <= 1'b0;
    end else begin
      w_we          <= w_we_nxt;
      w_addr        <= w_addr_nxt;
      pe_clr        <= pe_clr_nxt;
      pe_en         <= pe_en_nxt;
      pe_k          <= pe_k_nxt;
      out_valid     <= out_valid_nxt;
      busy          <= busy_nxt;
      weights_valid <= weights_valid_nxt;
      start_err     <= start_err_nxt;
      done          <= done_nxt;
    end
  end

`ifdef CONV_SA_CTRL_PERF_EN
  // Counts cycles from start acceptance to the result handshake; held in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 16'd0;
    end else if ((state == S_IDLE) && (state_nxt == S_CLEAR)) begin
      cycle_cnt <= 16'd0;
    end else if (((state == S_CLEAR) || (state == S_COMPUTE) ||
                  (state == S_DRAIN) || (state == S_OUT_WAIT)) &&
                 (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`else
  // Performance counter not built.
`endif

endmodule
`default_nettype wire
